// File: rtl/sclk_burst_ctrl_pkg.sv
// Shared definitions for divider-based serial clock blocks: state encoding
// and the default divider geometry.
package sclk_burst_ctrl_pkg;

    localparam int DEF_CNT_W    = 7;
    localparam int DEF_NCYC_W   = 5;
    localparam int DEF_DIV_HALF = 113;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/sclk_burst_ctrl_half_period_counter.sv
// Half-period counter: counts 0..limit while enabled and flags the wrap cycle.
// Dropping en clears the count so every burst starts on a fresh phase.
module half_period_counter
    import sclk_burst_ctrl_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [CNT_W-1:0] limit,
    output logic             wrap,
    output logic [CNT_W-1:0] cnt
);

    assign wrap = en && (cnt == limit);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (!en || wrap) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/sclk_burst_ctrl.sv
// Burst sequencer for a programmable half-period divider: emits N periods on
// s_clk, then parks s_clk low and pulses done. Ratio changes land on falls.
module sclk_burst_ctrl
    import sclk_burst_ctrl_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int NCYC_W      = DEF_NCYC_W,
    parameter int DIV_DEFAULT = DEF_DIV_HALF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic [CNT_W-1:0]  cfg_half,
    input  logic              start,
    input  logic [NCYC_W-1:0] ncycles,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              s_clk,
    output logic              rise_stb,
    output logic              fall_stb
);

    state_t             state;
    state_t             state_n;
    logic [CNT_W-1:0]   half;
    logic [CNT_W-1:0]   pend_half;
    logic               pend_valid;
    logic [NCYC_W-1:0]  remaining;
    logic [CNT_W-1:0]   cnt;
    logic               wrap;
    logic               run_en;
    logic               rise_tog;
    logic               fall_tog;
    logic               last_fall;
    logic               accept;
    logic               zero_req;
    logic               run_abort;

    half_period_counter #(
        .CNT_W (CNT_W)
    ) u_half_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (run_en),
        .limit (half),
        .wrap  (wrap),
        .cnt   (cnt)
    );

    // half only changes when cnt restarts at 0, so the count can never overshoot
    cnt_within_half: assert property (@(posedge clk) disable iff (reset) cnt <= half);

    always_comb begin
        state_n   = state;
        run_en    = (state == ST_RUN) && !abort;
        run_abort = (state == ST_RUN) && abort;
        rise_tog  = wrap && !s_clk;
        fall_tog  = wrap && s_clk;
        last_fall = fall_tog && (remaining <= NCYC_W'(1));
        accept    = (state == ST_IDLE) && start && !abort && (ncycles != '0);
        zero_req  = (state == ST_IDLE) && start && !abort && (ncycles == '0);
        case (state)
            ST_IDLE: if (accept) state_n = ST_RUN;
            ST_RUN:  if (abort || last_fall) state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    assign busy = (state == ST_RUN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_clk     <= 1'b0;
            rise_stb  <= 1'b0;
            fall_stb  <= 1'b0;
            done      <= 1'b0;
            remaining <= '0;
        end else begin
            rise_stb <= rise_tog;
            fall_stb <= fall_tog;
            done     <= zero_req || last_fall;
            if (!run_en) begin
                s_clk <= 1'b0;
            end else if (wrap) begin
                s_clk <= !s_clk;
            end
            if (accept) begin
                remaining <= ncycles;
            end else if (run_abort) begin
                remaining <= '0;
            end else if (fall_tog && (remaining != '0)) begin
                remaining <= remaining - NCYC_W'(1);
            end
        end
    end

    // In RUN every write is parked; it reaches half at the next fall, at abort,
    // or (for a write that coincided with the final fall) once back in IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            half       <= CNT_W'(DIV_DEFAULT);
            pend_half  <= '0;
            pend_valid <= 1'b0;
        end else if (state == ST_IDLE) begin
            if (cfg_we) begin
                half <= cfg_half;
            end else if (pend_valid) begin
                half <= pend_half;
            end
            pend_valid <= 1'b0;
        end else begin
            if ((fall_tog || abort) && pend_valid) begin
                half <= pend_half;
            end
            if (cfg_we) begin
                pend_half  <= cfg_half;
                pend_valid <= 1'b1;
            end else if (fall_tog || abort) begin
                pend_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sclk_burst_ctrl.sv
// Directed bench for sclk_burst_ctrl: burst timing, ratio changes, abort,
// zero-length requests and asynchronous reset.
module tb_sclk_burst_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       cfg_we;
    logic [6:0] cfg_half;
    logic       start;
    logic [4:0] ncycles;
    logic       abort;
    logic       busy;
    logic       done;
    logic       s_clk;
    logic       rise_stb;
    logic       fall_stb;

    int checks = 0;
    int failures = 0;

    int len, n_rise, n_fall, n_done, first_rise, done_n, last_fall_n, busy0, n_phase;
    int phase [0:31];

    sclk_burst_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .cfg_we   (cfg_we),
        .cfg_half (cfg_half),
        .start    (start),
        .ncycles  (ncycles),
        .abort    (abort),
        .busy     (busy),
        .done     (done),
        .s_clk    (s_clk),
        .rise_stb (rise_stb),
        .fall_stb (fall_stb)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_cfg_idle(input int v);
        cfg_we   = 1'b1;
        cfg_half = 7'(v);
        step();
        cfg_we = 1'b0;
    endtask

    // Starts a burst and measures it; n counts edges after the start edge.
    task automatic run_burst(input int ncyc, input int start_cfg, input int wr_at,
                             input int wr_val, input int abort_at, input int st_at);
        int n, last_tog;
        logic prev;
        len = 0; n_rise = 0; n_fall = 0; n_done = 0; first_rise = -1;
        done_n = -1; last_fall_n = -1; n_phase = 0;
        start   = 1'b1;
        ncycles = 5'(ncyc);
        if (start_cfg >= 0) begin
            cfg_we   = 1'b1;
            cfg_half = 7'(start_cfg);
        end
        step();
        start  = 1'b0;
        cfg_we = 1'b0;
        busy0  = int'(busy);
        n = 0; last_tog = 0; prev = s_clk;
        while (busy && n < 4000) begin
            cfg_we   = (n == wr_at);
            cfg_half = 7'(wr_val);
            abort    = (n == abort_at);
            start    = (n == st_at);
            if (n == st_at) ncycles = 5'd5;
            step();
            n++;
            cfg_we = 1'b0;
            abort  = 1'b0;
            start  = 1'b0;
            if (rise_stb) begin
                n_rise++;
                if (first_rise < 0) first_rise = n;
            end
            if (fall_stb) begin
                n_fall++;
                last_fall_n = n;
            end
            if (done) begin
                n_done++;
                done_n = n;
            end
            if (s_clk !== prev) begin
                if (n_phase < 32) phase[n_phase] = n - last_tog;
                n_phase++;
                last_tog = n;
                prev = s_clk;
            end
        end
        len = n;
    endtask

    task automatic test_reset();
        reset = 1'b1; cfg_we = 1'b0; cfg_half = '0; start = 1'b0; ncycles = '0; abort = 1'b0;
        #1;
        checks++;
        if ({busy, done, s_clk, rise_stb, fall_stb} !== 5'b0) begin
            failures++;
            $display("FAIL reset_outputs: got %b expected 00000", {busy, done, s_clk, rise_stb, fall_stb});
        end
        step(); step();
        #3 reset = 1'b0;
        step();
        checks++;
        if ({busy, done, s_clk, rise_stb, fall_stb} !== 5'b0) begin
            failures++;
            $display("FAIL after_reset_idle: got %b expected 00000", {busy, done, s_clk, rise_stb, fall_stb});
        end
    endtask

    task automatic test_default_burst();
        run_burst(2, -1, -1, 0, -1, -1);
        checks++;
        if (busy0 !== 1) begin failures++; $display("FAIL dflt_busy_after_start: got %0d expected 1", busy0); end
        checks++;
        if (len !== 456) begin failures++; $display("FAIL dflt_len: got %0d expected 456", len); end
        checks++;
        if (first_rise !== 114) begin failures++; $display("FAIL dflt_first_rise: got %0d expected 114", first_rise); end
        checks++;
        if (n_rise !== 2 || n_fall !== 2) begin
            failures++; $display("FAIL dflt_strobes: got rise=%0d fall=%0d expected 2/2", n_rise, n_fall);
        end
        checks++;
        if (n_done !== 1 || done_n !== 456 || last_fall_n !== 456) begin
            failures++;
            $display("FAIL dflt_done_align: got done=%0d at %0d last_fall %0d expected 1 at 456/456", n_done, done_n, last_fall_n);
        end
        step();
        checks++;
        if (s_clk !== 1'b0 || done !== 1'b0) begin
            failures++; $display("FAIL dflt_after: got s_clk=%b done=%b expected 0/0", s_clk, done);
        end
    endtask

    task automatic test_div_zero();
        int maxp;
        run_burst(3, 0, -1, 0, -1, -1);
        maxp = 0;
        for (int i = 0; i < n_phase && i < 32; i++) if (phase[i] > maxp) maxp = phase[i];
        checks++;
        if (len !== 6) begin failures++; $display("FAIL div0_len: got %0d expected 6", len); end
        checks++;
        if (n_rise !== 3 || first_rise !== 1) begin
            failures++; $display("FAIL div0_rises: got %0d first at %0d expected 3 first at 1", n_rise, first_rise);
        end
        checks++;
        if (n_phase !== 6 || maxp !== 1) begin
            failures++; $display("FAIL div0_phases: got count=%0d max=%0d expected 6/1", n_phase, maxp);
        end
    endtask

    task automatic test_midburst_cfg();
        int expp [0:5];
        int bad;
        expp = '{5, 5, 10, 10, 10, 10};
        write_cfg_idle(4);
        run_burst(3, -1, 7, 9, -1, -1);
        checks++;
        if (len !== 50) begin failures++; $display("FAIL mid_len: got %0d expected 50", len); end
        checks++;
        if (n_phase !== 6) begin failures++; $display("FAIL mid_phase_count: got %0d expected 6", n_phase); end
        bad = 0;
        for (int i = 0; i < 6; i++) if (phase[i] !== expp[i]) bad++;
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL mid_phases: got %0d %0d %0d %0d %0d %0d expected 5 5 10 10 10 10",
                     phase[0], phase[1], phase[2], phase[3], phase[4], phase[5]);
        end
    endtask

    task automatic test_abort();
        write_cfg_idle(4);
        run_burst(4, -1, -1, 0, 16, -1);
        checks++;
        if (len !== 17) begin failures++; $display("FAIL abort_len: got %0d expected 17", len); end
        checks++;
        if (n_rise !== 2 || n_fall !== 1 || n_done !== 0) begin
            failures++;
            $display("FAIL abort_strobes: got rise=%0d fall=%0d done=%0d expected 2/1/0", n_rise, n_fall, n_done);
        end
        checks++;
        if (s_clk !== 1'b0) begin failures++; $display("FAIL abort_sclk: got %b expected 0", s_clk); end
        step();
        checks++;
        if (done !== 1'b0 || fall_stb !== 1'b0) begin
            failures++; $display("FAIL abort_after: got done=%b fall=%b expected 0/0", done, fall_stb);
        end
        run_burst(1, -1, -1, 0, -1, -1);
        checks++;
        if (len !== 10 || n_done !== 1 || first_rise !== 5) begin
            failures++;
            $display("FAIL abort_restart: got len=%0d done=%0d rise@%0d expected 10/1/5", len, n_done, first_rise);
        end
    endtask

    task automatic test_zero_and_ignored_start();
        start = 1'b1; ncycles = 5'd0;
        step();
        start = 1'b0;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            failures++; $display("FAIL zero_done: got done=%b busy=%b expected 1/0", done, busy);
        end
        step();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL zero_after: got done=%b busy=%b expected 0/0", done, busy);
        end
        start = 1'b1; abort = 1'b1; ncycles = 5'd2;
        step();
        start = 1'b0; abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++; $display("FAIL abort_wins: got busy=%b done=%b expected 0/0", busy, done);
        end
        run_burst(2, -1, -1, 0, -1, 3);
        checks++;
        if (len !== 20 || n_rise !== 2 || n_done !== 1) begin
            failures++;
            $display("FAIL run_start_ignored: got len=%0d rise=%0d done=%0d expected 20/2/1", len, n_rise, n_done);
        end
    endtask

    task automatic test_back_to_back();
        run_burst(1, -1, -1, 0, -1, -1);
        run_burst(1, -1, -1, 0, -1, -1);
        checks++;
        if (busy0 !== 1 || len !== 10 || n_done !== 1) begin
            failures++;
            $display("FAIL b2b_second: got busy0=%0d len=%0d done=%0d expected 1/10/1", busy0, len, n_done);
        end
    endtask

    task automatic test_reset_midburst();
        int w;
        start = 1'b1; ncycles = 5'd4;
        step();
        start = 1'b0;
        step(); step();
        cfg_we = 1'b1; cfg_half = 7'd9;
        step();
        cfg_we = 1'b0;
        w = 0;
        while (s_clk !== 1'b1 && w < 50) begin
            step();
            w++;
        end
        checks++;
        if (s_clk !== 1'b1) begin failures++; $display("FAIL rst_mid_reach_high: got %b expected 1", s_clk); end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (s_clk !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL rst_mid_async: got s_clk=%b busy=%b expected 0/0", s_clk, busy);
        end
        step();
        #3 reset = 1'b0;
        step();
        run_burst(1, -1, -1, 0, -1, -1);
        checks++;
        if (len !== 228 || first_rise !== 114) begin
            failures++; $display("FAIL rst_mid_default_half: got len=%0d rise@%0d expected 228/114", len, first_rise);
        end
    endtask

    initial begin
        test_reset();
        test_default_burst();
        test_div_zero();
        test_midburst_cfg();
        test_abort();
        test_zero_and_ignored_start();
        test_back_to_back();
        test_reset_midburst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sclk_burst_ctrl.md
# sclk_burst_ctrl

Sequencer for a programmable half-period clock divider: on request it emits a burst of exactly N divided-clock periods on `s_clk`, then returns `s_clk` low and pulses `done`. It sits between the bus/peripheral controllers and the serial clock line, sharing one configurable divider among transactions. The division ratio is runtime-configurable, and a new ratio applied mid-burst takes effect only at a period boundary, so `s_clk` never glitches.

## Interface
- `CNT_W`, default 7: half-period counter width.
- `NCYC_W`, default 5: burst-length width.
- `DIV_DEFAULT`, default 113: reset value of the half-period register, giving a phase of 114 clk cycles.

- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `cfg_we` in 1: write strobe for `cfg_half`.
- `cfg_half` in CNT_W: new half-period value; phase length is `cfg_half`+1 cycles.
- `start` in 1: request a burst; sampled only in IDLE.
- `ncycles` in NCYC_W: number of full `s_clk` periods in the burst.
- `abort` in 1: terminate the current burst.
- `busy` out 1: high while in RUN.
- `done` out 1: one-cycle pulse when a burst completes normally.
- `s_clk` out 1: divided clock, registered.
- `rise_stb` out 1: one-cycle pulse coincident with the `s_clk` 0→1 transition.
- `fall_stb` out 1: one-cycle pulse coincident with the `s_clk` 1→0 transition.

## Operation
- Registers: `half` (CNT_W), `pend_half`, `pend_valid`, `cnt` (CNT_W), `remaining` (NCYC_W), `state` ∈ {IDLE, RUN}.
- Reset values: `state`=IDLE; `half`=DIV_DEFAULT; `pend_valid`=0; `cnt`=0; `remaining`=0. All outputs are 0.

IDLE:
- `cfg_we` writes `half` directly.
- `start` with `ncycles`≠0: `remaining`←`ncycles`, `cnt`←0, `s_clk`←0, state→RUN.
- If `cfg_we` and `start` arrive together, the burst uses the new `cfg_half`.
- `start` with `ncycles`=0: no state change; `done` pulses on the next edge.
- `abort` in IDLE is ignored. If `abort` and `start` arrive together, `abort` wins and the start is dropped.

RUN:
- `cnt` increments each cycle until `cnt`==`half`. At that point `cnt`←0 and `s_clk` toggles.
- On the 0→1 toggle: `rise_stb`←1.
- On the 1→0 toggle:
  - `fall_stb`←1 and `remaining`←`remaining`−1.
  - If `pend_valid`: `half`←`pend_half` and `pend_valid`←0.
  - If `remaining`==1: state→IDLE, `busy`←0, `done`←1. These land on the same edge as the last `fall_stb`.
- `cfg_we` in RUN always writes `pend_half` and sets `pend_valid`; the last write wins. A write in the same cycle as a falling toggle lands in pending and is applied at the following fall. Pending is also applied on the return to IDLE.
- `start` in RUN is ignored, with no queuing.
- `abort` in RUN:
  - Next edge: state→IDLE, `s_clk`←0, `cnt`←0, `remaining`←0.
  - No `done`, no strobes. If `s_clk` was high, no `fall_stb` is issued.
  - Pending config is applied.
- Arithmetic: `cnt` compare is equality only. `half`=0 is legal and gives a 1-cycle phase (clk/2). `remaining` never underflows.
- Reset mid-burst: `s_clk` drops immediately (async); `half` returns to DIV_DEFAULT; pending is discarded.

## Timing
- `start` sampled at edge k → `busy`=1 after k.
- First rising `s_clk` at edge k+`half`+1.
- Every phase lasts `half`+1 cycles.
- Burst length from `busy` rising to `busy` falling: 2·N·(`half`+1) cycles.
  - Default values: 228 cycles per period, ≈438.6 kHz from 100 MHz.
- `busy` and `s_clk` fall, and `done` pulses, on the same edge.
- A new `start` is accepted on the cycle after `done`, giving back-to-back bursts with one idle cycle.
- Strobes are registered, aligned with the `s_clk` edge and exactly one cycle wide.

## Structure
- Shared package holds:
  - the state encoding (IDLE/RUN);
  - DIV_DEFAULT and the default CNT_W/NCYC_W constants, for reuse by other divider-based blocks.
- One sub-module: `half_period_counter`, with inputs clk, reset, en, limit and outputs `wrap` and `cnt`. It performs the equality-compare wrap.
- The FSM, pending-config logic and `remaining` counter live in the top module.

## Test plan
- Reset, then `start`, `ncycles`=2, default `half` → `busy` for 456 cycles. Exactly 2 `rise_stb` and 2 `fall_stb`; first rise 114 cycles after `busy`; `done` on the last fall; `s_clk`=0 after.
- IDLE `cfg_half`=0, `start`, `ncycles`=3 → `s_clk` toggles every cycle; `busy` lasts 6 cycles; 3 rises.
- Mid-burst `cfg_half`=9 written during a high phase, `ncycles`=3, `half`=4 → the current period keeps 5-cycle phases; later periods use 10-cycle phases; no short pulse.
- `abort` while `s_clk`=1 in the second of 4 periods → `s_clk`, `busy` low the next edge; no `done`, no `fall_stb`; a subsequent `start` works normally.
- `start` with `ncycles`=0 → `done` one cycle later, `busy` never high. `start` during RUN → ignored, the burst count is unchanged.
- Async `reset` mid-burst → `s_clk`=0 immediately. A later `start` uses `half`=113 even if a pending write existed.
